// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//   Shares the single main-memory port between the icache refill path and the
//   dcache refill/writeback path. One block transaction is in flight at a time.
//   Conflicting requests are granted round-robin. The memory request uses a
//   valid/ready handshake. The registered response is routed back to the
//   requester that owns the transaction.
//   An icache fetch redirect (icache_req_cancel) lets the memory transaction
//   finish, but its response is discarded instead of being delivered.
//
// Ports
//   clk, rst_aL                 clock, synchronous active-low reset
//   icache_req_*                icache refill request (valid/ready, block addr)
//   icache_req_cancel           drop the pending icache response
//   icache_resp_valid/_data     one-cycle refill strobe and block
//   dcache_req_*                dcache request (valid/ready, wr, addr, wr data)
//   dcache_resp_valid/_data     one-cycle completion strobe; data 0 on write ack
//   mem_req_*                   main-memory request (valid/ready, wr, addr, data)
//   mem_resp_valid/_data        main-memory response strobe and block

module mem_req_arbiter #(
  parameter int BLOCK_ADDR_WIDTH = 29,
  parameter int BLOCK_DATA_WIDTH = 64
) (
  input  logic                        clk,
  input  logic                        rst_aL,
  input  logic                        icache_req_valid,
  output logic                        icache_req_ready,
  input  logic [BLOCK_ADDR_WIDTH-1:0] icache_req_block_addr,
  input  logic                        icache_req_cancel,
  output logic                        icache_resp_valid,
  output logic [BLOCK_DATA_WIDTH-1:0] icache_resp_data,
  input  logic                        dcache_req_valid,
  output logic                        dcache_req_ready,
  input  logic                        dcache_req_wr,
  input  logic [BLOCK_ADDR_WIDTH-1:0] dcache_req_block_addr,
  input  logic [BLOCK_DATA_WIDTH-1:0] dcache_req_wr_data,
  output logic                        dcache_resp_valid,
  output logic [BLOCK_DATA_WIDTH-1:0] dcache_resp_data,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic                        mem_req_wr,
  output logic [BLOCK_ADDR_WIDTH-1:0] mem_req_block_addr,
  output logic [BLOCK_DATA_WIDTH-1:0] mem_req_wr_data,
  input  logic                        mem_resp_valid,
  input  logic [BLOCK_DATA_WIDTH-1:0] mem_resp_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic OWNER_ICACHE = 1'b0;
  localparam logic OWNER_DCACHE = 1'b1;

  state_t                      state_reg, state_next;
  logic                        owner_reg, owner_next;
  logic                        last_winner_reg, last_winner_next;
  logic                        drop_reg, drop_next;
  logic                        wr_reg, wr_next;
  logic [BLOCK_ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [BLOCK_DATA_WIDTH-1:0] wr_data_reg, wr_data_next;
  logic [BLOCK_DATA_WIDTH-1:0] resp_data_reg, resp_data_next;

  logic grant_icache;
  logic grant_dcache;
  logic cancel_hit;

  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      state_reg       <= IDLE;
      owner_reg       <= OWNER_ICACHE;
      // Pretend icache won last so that dcache wins the first tie.
      last_winner_reg <= OWNER_ICACHE;
      drop_reg        <= 1'b0;
      wr_reg          <= 1'b0;
      addr_reg        <= '0;
      wr_data_reg     <= '0;
      resp_data_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      owner_reg       <= owner_next;
      last_winner_reg <= last_winner_next;
      drop_reg        <= drop_next;
      wr_reg          <= wr_next;
      addr_reg        <= addr_next;
      wr_data_reg     <= wr_data_next;
      resp_data_reg   <= resp_data_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    owner_next        = owner_reg;
    last_winner_next  = last_winner_reg;
    drop_next         = drop_reg;
    wr_next           = wr_reg;
    addr_next         = addr_reg;
    wr_data_next      = wr_data_reg;
    resp_data_next    = resp_data_reg;
    grant_icache      = 1'b0;
    grant_dcache      = 1'b0;
    icache_req_ready  = 1'b0;
    dcache_req_ready  = 1'b0;
    icache_resp_valid = 1'b0;
    dcache_resp_valid = 1'b0;
    mem_req_valid     = 1'b0;
    cancel_hit        = icache_req_cancel && (owner_reg == OWNER_ICACHE);

    case (state_reg)
      IDLE: begin
        // dcache wins a tie only when icache took the previous grant.
        grant_dcache     = dcache_req_valid &&
                           (!icache_req_valid || (last_winner_reg == OWNER_ICACHE));
        grant_icache     = icache_req_valid && !grant_dcache;
        icache_req_ready = grant_icache;
        dcache_req_ready = grant_dcache;
        if (grant_icache) begin
          owner_next       = OWNER_ICACHE;
          last_winner_next = OWNER_ICACHE;
          wr_next          = 1'b0;
          addr_next        = icache_req_block_addr;
          wr_data_next     = '0;
          // A redirect in the accept cycle already applies to this fetch.
          drop_next        = icache_req_cancel;
          state_next       = ISSUE;
        end else if (grant_dcache) begin
          owner_next       = OWNER_DCACHE;
          last_winner_next = OWNER_DCACHE;
          wr_next          = dcache_req_wr;
          addr_next        = dcache_req_block_addr;
          wr_data_next     = dcache_req_wr_data;
          drop_next        = 1'b0;
          state_next       = ISSUE;
        end
      end

      ISSUE: begin
        mem_req_valid = 1'b1;
        if (cancel_hit) drop_next = 1'b1;
        if (mem_req_ready) state_next = WAIT;
      end

      WAIT: begin
        if (cancel_hit) drop_next = 1'b1;
        if (mem_resp_valid) begin
          if (drop_reg || cancel_hit) begin
            // Cancelled fetch: the memory side is done, nothing is delivered.
            drop_next  = 1'b0;
            state_next = IDLE;
          end else begin
            resp_data_next = wr_reg ? '0 : mem_resp_data;
            state_next     = RESP;
          end
        end
      end

      RESP: begin
        icache_resp_valid = (owner_reg == OWNER_ICACHE);
        dcache_resp_valid = (owner_reg == OWNER_DCACHE);
        state_next        = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign mem_req_wr         = wr_reg;
  assign mem_req_block_addr = addr_reg;
  assign mem_req_wr_data    = wr_data_reg;

  // Only the owning cache sees the block; the other data bus stays quiet.
  assign icache_resp_data = icache_resp_valid ? resp_data_reg : '0;
  assign dcache_resp_data = dcache_resp_valid ? resp_data_reg : '0;

endmodule

// File: tb/tb_mem_req_arbiter.sv
module tb_mem_req_arbiter;
  localparam int AW = 29;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_aL = 1'b0;
  logic          icache_req_valid = 1'b0;
  logic          icache_req_ready;
  logic [AW-1:0] icache_req_block_addr = '0;
  logic          icache_req_cancel = 1'b0;
  logic          icache_resp_valid;
  logic [DW-1:0] icache_resp_data;
  logic          dcache_req_valid = 1'b0;
  logic          dcache_req_ready;
  logic          dcache_req_wr = 1'b0;
  logic [AW-1:0] dcache_req_block_addr = '0;
  logic [DW-1:0] dcache_req_wr_data = '0;
  logic          dcache_resp_valid;
  logic [DW-1:0] dcache_resp_data;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic          mem_req_wr;
  logic [AW-1:0] mem_req_block_addr;
  logic [DW-1:0] mem_req_wr_data;
  logic          mem_resp_valid = 1'b0;
  logic [DW-1:0] mem_resp_data = '0;

  mem_req_arbiter #(.BLOCK_ADDR_WIDTH(AW), .BLOCK_DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_aL(rst_aL),
    .icache_req_valid(icache_req_valid), .icache_req_ready(icache_req_ready),
    .icache_req_block_addr(icache_req_block_addr), .icache_req_cancel(icache_req_cancel),
    .icache_resp_valid(icache_resp_valid), .icache_resp_data(icache_resp_data),
    .dcache_req_valid(dcache_req_valid), .dcache_req_ready(dcache_req_ready),
    .dcache_req_wr(dcache_req_wr), .dcache_req_block_addr(dcache_req_block_addr),
    .dcache_req_wr_data(dcache_req_wr_data),
    .dcache_resp_valid(dcache_resp_valid), .dcache_resp_data(dcache_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wr(mem_req_wr), .mem_req_block_addr(mem_req_block_addr),
    .mem_req_wr_data(mem_req_wr_data),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          who;   // 0 = icache, 1 = dcache
    logic [DW-1:0] data;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  logic      grant_log[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Memory model configuration and bookkeeping.
  int            latency = 4;
  int            stall_cfg = 0;
  int            stall_left = 0;
  int            cnt = 0;
  int            hs_cnt = 0;
  int            last_resp_cyc = -10;
  bit            pend = 0;
  bit            seen = 0;
  bit            spur_req = 0;
  logic          p_wr = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic          c_wr = 1'b0;
  logic [AW-1:0] c_addr = '0;
  logic [DW-1:0] c_data = '0;

  // Last accepted request as seen at the cache side.
  int            acc_cyc = -10;
  logic          acc_wr = 1'b0;
  logic [AW-1:0] acc_addr = '0;
  logic [DW-1:0] acc_data = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    return {a, 35'h0} ^ {35'h0, a} ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Main-memory model: optional ready stall, fixed response latency,
  // and an on-demand spurious response.
  initial forever begin
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    if (spur_req) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = 64'hBAD0_BAD0_BAD0_BAD0;
      spur_req       = 0;
    end
    if (pend) begin
      if (cnt == 0) begin
        mem_resp_valid = 1'b1;
        // Write acks carry junk that the arbiter must not forward.
        mem_resp_data  = p_wr ? 64'hFFFF_FFFF_FFFF_FFFF : mem_data(p_addr);
        pend           = 0;
        last_resp_cyc  = cyc;
      end else begin
        cnt--;
      end
    end
    mem_req_ready = 1'b0;
    if (mem_req_valid) begin
      if (!seen) begin
        seen       = 1;
        stall_left = stall_cfg;
        c_addr     = mem_req_block_addr;
        c_wr       = mem_req_wr;
        c_data     = mem_req_wr_data;
        check("issue_latency", 64'(cyc), 64'(acc_cyc + 1));
        check("issue_addr", 64'(mem_req_block_addr), 64'(acc_addr));
        check("issue_wr", 64'(mem_req_wr), 64'(acc_wr));
        if (acc_wr) check("issue_wr_data", mem_req_wr_data, acc_data);
      end else begin
        check("stall_addr", 64'(mem_req_block_addr), 64'(c_addr));
        check("stall_wr", 64'(mem_req_wr), 64'(c_wr));
        check("stall_wr_data", mem_req_wr_data, c_data);
      end
      if (stall_left > 0) begin
        stall_left--;
      end else begin
        mem_req_ready = 1'b1;
        pend          = 1;
        cnt           = latency - 1;
        p_addr        = mem_req_block_addr;
        p_wr          = mem_req_wr;
        seen          = 0;
        hs_cnt++;
      end
    end
  end

  // Monitor: accepts push the expected response, responses pop and compare.
  initial forever begin
    @(negedge clk);
    #2;
    if (icache_req_ready && dcache_req_ready) check("both_ready", 1, 0);
    if (icache_req_ready && !icache_req_valid) check("icache_ready_no_valid", 1, 0);
    if (dcache_req_ready && !dcache_req_valid) check("dcache_ready_no_valid", 1, 0);
    if (icache_req_valid && icache_req_ready) begin
      grant_log.push_back(1'b0);
      acc_cyc  = cyc;
      acc_wr   = 1'b0;
      acc_addr = icache_req_block_addr;
      acc_data = '0;
      sb_q.push_back('{who: 1'b0, data: mem_data(icache_req_block_addr)});
    end else if (dcache_req_valid && dcache_req_ready) begin
      grant_log.push_back(1'b1);
      acc_cyc  = cyc;
      acc_wr   = dcache_req_wr;
      acc_addr = dcache_req_block_addr;
      acc_data = dcache_req_wr_data;
      sb_q.push_back('{who: 1'b1,
                       data: dcache_req_wr ? '0 : mem_data(dcache_req_block_addr)});
    end
    if (icache_resp_valid || dcache_resp_valid) begin
      check("resp_onehot", 64'(icache_resp_valid && dcache_resp_valid), 0);
      if (sb_q.size() == 0) begin
        check("unexpected_resp", 1, 0);
      end else begin
        sb_entry_t e;
        e = sb_q.pop_front();
        check("resp_owner", 64'(dcache_resp_valid), 64'(e.who));
        check("resp_data", dcache_resp_valid ? dcache_resp_data : icache_resp_data, e.data);
        check("resp_latency", 64'(cyc), 64'(last_resp_cyc + 1));
        $display("resp %s data=%h cycle=%0d", e.who ? "dcache" : "icache",
                 dcache_resp_valid ? dcache_resp_data : icache_resp_data, cyc);
      end
    end
  end

  // Tasks below expect to be called shortly after a falling edge.
  task automatic drive_i(input logic [AW-1:0] a);
    int n = 0;
    icache_req_valid      = 1'b1;
    icache_req_block_addr = a;
    #1;
    while (!icache_req_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (!icache_req_ready) check("icache_accept_timeout", 0, 1);
    @(negedge clk); #1;
    icache_req_valid = 1'b0;
  endtask

  task automatic drive_d(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    dcache_req_valid      = 1'b1;
    dcache_req_wr         = wr;
    dcache_req_block_addr = a;
    dcache_req_wr_data    = d;
    #1;
    while (!dcache_req_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (!dcache_req_ready) check("dcache_accept_timeout", 0, 1);
    @(negedge clk); #1;
    dcache_req_valid = 1'b0;
    dcache_req_wr    = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge clk); #3; n++;
    end
    if (sb_q.size() != 0) check("drain_timeout", 64'(sb_q.size()), 0);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic wait_hs(input int prev);
    int n = 0;
    while (hs_cnt == prev && n < 100) begin
      @(negedge clk); #3; n++;
    end
    if (hs_cnt == prev) check("mem_handshake_timeout", 0, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_mem_req_valid"}, 64'(mem_req_valid), 0);
    check({tag, "_icache_ready"}, 64'(icache_req_ready), 0);
    check({tag, "_dcache_ready"}, 64'(dcache_req_ready), 0);
    check({tag, "_icache_resp_valid"}, 64'(icache_resp_valid), 0);
    check({tag, "_dcache_resp_valid"}, 64'(dcache_resp_valid), 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_aL = 1'b0;
    sb_q.delete();
    @(negedge clk); #1;
    check_idle_outputs("reset");
    rst_aL = 1'b1;
  endtask

  initial begin
    logic exp_grant [4];
    int   prev;
    int   n;

    // Power-on reset: every output low.
    repeat (2) @(negedge clk);
    #1;
    check_idle_outputs("por");
    check("por_mem_addr", 64'(mem_req_block_addr), 0);
    check("por_mem_wr", 64'(mem_req_wr), 0);
    check("por_mem_wr_data", mem_req_wr_data, 0);
    check("por_icache_resp_data", icache_resp_data, 0);
    check("por_dcache_resp_data", dcache_resp_data, 0);
    rst_aL = 1'b1;

    // Single icache refill, latency 4, ready immediately.
    latency = 4;
    @(negedge clk); #1;
    drive_i(29'h080C);
    wait_drain();

    // Simultaneous requests from reset: d, i, d, i.
    do_reset();
    latency = 2;
    grant_log.delete();
    @(negedge clk); #1;
    icache_req_block_addr = 29'h0100;
    dcache_req_block_addr = 29'h0200;
    dcache_req_wr         = 1'b0;
    icache_req_valid      = 1'b1;
    dcache_req_valid      = 1'b1;
    n = 0;
    while (grant_log.size() < 4 && n < 300) begin
      @(negedge clk); #3; n++;
    end
    @(negedge clk); #1;
    icache_req_valid = 1'b0;
    dcache_req_valid = 1'b0;
    check("grant_count", 64'(grant_log.size()), 4);
    exp_grant = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      if (i < grant_log.size())
        check($sformatf("grant_order_%0d", i), 64'(grant_log[i]), 64'(exp_grant[i]));
    end
    wait_drain();

    // dcache writeback with ready held low for 3 cycles.
    latency   = 3;
    stall_cfg = 3;
    drive_d(1'b1, 29'h0010, 64'hDEAD_BEEF_CAFE_F00D);
    wait_drain();
    stall_cfg = 0;

    // icache refill cancelled 2 cycles into WAIT, dcache waiting behind it.
    latency = 6;
    prev    = hs_cnt;
    drive_i(29'h0ABC);
    wait_hs(prev);
    repeat (2) @(negedge clk);
    #1;
    icache_req_cancel = 1'b1;
    void'(sb_q.pop_back());
    @(negedge clk); #1;
    icache_req_cancel = 1'b0;
    drive_d(1'b0, 29'h0DEF, '0);
    check("cancel_next_accept", 64'(acc_cyc), 64'(last_resp_cyc + 1));
    wait_drain();

    // Reset during WAIT; the stale response must be ignored.
    latency = 8;
    prev    = hs_cnt;
    drive_i(29'h0300);
    wait_hs(prev);
    repeat (2) @(negedge clk);
    #1;
    rst_aL = 1'b0;
    sb_q.delete();
    @(negedge clk); #1;
    check_idle_outputs("midreset");
    rst_aL = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    latency = 3;
    drive_d(1'b0, 29'h0400, '0);
    wait_drain();

    // Spurious memory response while idle.
    spur_req = 1;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("spurious");
    drive_i(29'h0555);
    wait_drain();

    check("final_scoreboard_empty", 64'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
